// File: rtl/riscv_params_pkg.sv
// riscv_params_pkg: shared widths, size encodings and request
// bundle for the load/store unit slice.
package riscv_params_pkg;

   localparam int DEF_XLEN           = 32;
   localparam int DEF_DATA_MEM_DEPTH = 1024;
   localparam int ADDR_WIDTH         = 5;

   typedef enum logic [2:0] {
      SZ_B  = 3'b000,
      SZ_H  = 3'b001,
      SZ_W  = 3'b010,
      SZ_BU = 3'b100,
      SZ_HU = 3'b101
   } lsu_size_e;

   typedef enum logic {
      IDLE,
      WAIT
   } lsu_state_e;

   typedef struct packed {
      logic                    is_ld;
      logic                    is_st;
      logic [2:0]              funct3;
      logic [DEF_XLEN-1:0]     addr;
      logic [DEF_XLEN-1:0]     st_data;
      logic [ADDR_WIDTH-1:0]   rd;
   } lsu_req_t;

   function automatic logic ld_legal(input logic [2:0] f3);
      return f3 inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};
   endfunction

   function automatic logic st_legal(input logic [2:0] f3);
      return f3 inside {SZ_B, SZ_H, SZ_W};
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response bundle between the
// execute stage and the load/store unit.
interface load_store_unit_if
   import riscv_params_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic                  is_ld;
   logic                  is_st;
   logic [2:0]            funct3;
   logic [XLEN-1:0]       addr;
   logic [XLEN-1:0]       st_data;
   logic [ADDR_WIDTH-1:0] rd_in;
   logic                  out_valid;
   logic [XLEN-1:0]       result;
   logic [ADDR_WIDTH-1:0] rd_out;
   logic                  exc_misalign;
   logic                  exc_range;
   logic                  exc_illegal;

   modport master (
      output in_valid, is_ld, is_st, funct3, addr, st_data, rd_in,
      input  in_ready, out_valid, result, rd_out,
      input  exc_misalign, exc_range, exc_illegal
   );

   modport slave (
      input  in_valid, is_ld, is_st, funct3, addr, st_data, rd_in,
      output in_ready, out_valid, result, rd_out,
      output exc_misalign, exc_range, exc_illegal
   );

endinterface

// File: rtl/lsu_data_align.sv
// lsu_data_align: byte-lane steering, byte enables and load
// sign/zero extension for one 32-bit memory word.
module lsu_data_align
   import riscv_params_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic [2:0]        funct3,
   input  logic [1:0]        lane,
   input  logic [XLEN-1:0]   st_data,
   input  logic [XLEN-1:0]   rdata,
   output logic [XLEN-1:0]   wdata,
   output logic [XLEN/8-1:0] be,
   output logic [XLEN-1:0]   ld_data
);

   localparam int BW = XLEN / 8;

   logic [4:0]      sh;
   logic [XLEN-1:0] shifted;

   assign sh      = {lane, 3'b000};
   assign wdata   = st_data << sh;
   assign shifted = rdata >> sh;

   always_comb begin
      be      = '1;
      ld_data = shifted;
      case (funct3)
         SZ_B: begin
            be      = BW'(1) << lane;
            ld_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         end
         SZ_BU: begin
            be      = BW'(1) << lane;
            ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
         end
         SZ_H: begin
            be      = BW'(3) << lane;
            ld_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         end
         SZ_HU: begin
            be      = BW'(3) << lane;
            ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
         end
         default: begin
            be      = '1;
            ld_data = shifted;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: fixed-latency data memory access stage with
// alignment, range and encoding checks.
module load_store_unit
   import riscv_params_pkg::*;
#(
   parameter int XLEN           = DEF_XLEN,
   parameter int DATA_MEM_DEPTH = DEF_DATA_MEM_DEPTH,
   parameter int MEM_LATENCY    = 1
) (
   input logic             clk,
   input logic             rst,
   load_store_unit_if.slave bus
);

   localparam int         IW       = $clog2(DATA_MEM_DEPTH);
   localparam int         BW       = XLEN / 8;
   localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

   lsu_state_e state;
   logic [2:0] cnt;
   lsu_req_t   req_q;
   lsu_req_t   in_req;
   lsu_req_t   cur;

   logic [XLEN-1:0] mem [DATA_MEM_DEPTH] = '{default: '0};

   logic            accept;
   logic            mem_op;
   logic            fire;
   logic [XLEN-3:0] word_idx;
   logic [IW-1:0]   idx;
   logic            ill;
   logic            mis;
   logic            rng;
   logic            err_mis;
   logic            err_rng;
   logic            err;
   logic            we;
   logic [XLEN-1:0] rdata;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] ld_data;
   logic [XLEN-1:0] res;
   logic [BW-1:0]   be;

   assign in_req = '{
      is_ld:   bus.is_ld,
      is_st:   bus.is_st,
      funct3:  bus.funct3,
      addr:    bus.addr,
      st_data: bus.st_data,
      rd:      bus.rd_in
   };

   // WAIT replays the latched request; IDLE works on the live one
   assign cur    = (state == IDLE) ? in_req : req_q;
   assign accept = bus.in_valid && (state == IDLE);
   assign mem_op = cur.is_ld || cur.is_st;
   assign fire   = (accept && (!mem_op || MEM_LATENCY == 1))
                || (state == WAIT && cnt == 3'd1);

   assign bus.in_ready = (state == IDLE);

   assign word_idx = cur.addr[XLEN-1:2];
   assign idx      = word_idx[IW-1:0];

   assign ill = (cur.is_ld && cur.is_st)
             || (cur.is_ld && !ld_legal(cur.funct3))
             || (cur.is_st && !st_legal(cur.funct3));

   assign mis = mem_op
             && ((cur.funct3[1:0] == 2'b01 && cur.addr[0])
             ||  (cur.funct3[1:0] == 2'b10 && cur.addr[1:0] != 2'b00));

   assign rng = mem_op
             && ({2'b00, word_idx} >= XLEN'(DATA_MEM_DEPTH));

   assign err_mis = !ill && mis;
   assign err_rng = !ill && !mis && rng;
   assign err     = ill || mis || rng;
   assign we      = fire && cur.is_st && !err;
   assign rdata   = mem[idx];

   lsu_data_align #(.XLEN(XLEN)) u_align (
      .funct3  (cur.funct3),
      .lane    (cur.addr[1:0]),
      .st_data (cur.st_data),
      .rdata   (rdata),
      .wdata   (wdata),
      .be      (be),
      .ld_data (ld_data)
   );

   always_comb begin
      res = '0;
      if (!err) begin
         if (cur.is_ld)
            res = ld_data;
         else if (!cur.is_st)
            res = cur.addr;
      end
   end

   // contents survive reset on purpose
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < BW; b++) begin
            if (be[b])
               mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         cnt              <= '0;
         req_q            <= '0;
         bus.out_valid    <= 1'b0;
         bus.result       <= '0;
         bus.rd_out       <= '0;
         bus.exc_misalign <= 1'b0;
         bus.exc_range    <= 1'b0;
         bus.exc_illegal  <= 1'b0;
      end else begin
         bus.out_valid <= fire;
         if (fire) begin
            bus.result       <= res;
            bus.rd_out       <= cur.rd;
            bus.exc_misalign <= err_mis;
            bus.exc_range    <= err_rng;
            bus.exc_illegal  <= ill;
         end
         unique case (state)
            IDLE: begin
               if (accept && mem_op && MEM_LATENCY > 1) begin
                  state <= WAIT;
                  cnt   <= CNT_INIT;
                  req_q <= in_req;
               end
            end
            WAIT: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width (32 only in this revision).
REQ-002 SHALL have parameter DATA_MEM_DEPTH, default 1024, number of XLEN-bit words.
REQ-003 SHALL have parameter MEM_LATENCY, default 1, range 1..8, cycles per memory access.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high at a rising edge.
REQ-008 SHALL have ports is_ld / is_st  input  1 each  operation type; neither set means pass-through.
REQ-009 SHALL have port funct3  input  3  access size and sign.
REQ-010 SHALL have port addr  input  XLEN  byte address, equal to the ALU result.
REQ-011 SHALL have port st_data  input  XLEN  store data, already forwarded.
REQ-012 SHALL have port rd_in  input  ADDR_WIDTH  destination register.
REQ-013 SHALL have port out_valid  output  1  single-cycle result strobe; no backpressure.
REQ-014 SHALL have ports result  output  XLEN  and  rd_out  output  ADDR_WIDTH: load data or pass-through addr, and the destination register.
REQ-015 SHALL have ports exc_misalign / exc_range / exc_illegal  output  1 each  error flags, valid with out_valid.

Function
REQ-016 SHALL decode loads as funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; every other funct3 on a load is illegal.
REQ-017 SHALL decode stores as funct3 000 SB, 001 SH, 010 SW; every other funct3 on a store is illegal.
REQ-018 SHALL flag illegal when is_ld and is_st are both high.
REQ-019 SHALL index memory with addr[XLEN-1:2] and byte lane addr[1:0]; little-endian.
REQ-020 SHALL flag misaligned for a halfword with addr[0]=1 and for a word with addr[1:0]!=0.
REQ-021 SHALL flag out-of-range when the word index is >= DATA_MEM_DEPTH.
REQ-022 SHALL apply error priority illegal > misalign > range; exactly one flag is set; on any error there is no memory write and result=0.
REQ-023 SHALL write only the addressed bytes for SB/SH; other bytes of the word are unchanged.
REQ-024 SHALL sign-extend LB/LH and zero-extend LBU/LHU to XLEN.
REQ-025 SHALL use FSM states IDLE and WAIT; in_ready=1 in IDLE and 0 in WAIT.
REQ-026 SHALL, for a pass-through request accepted at edge T, pulse out_valid in the cycle after T with result=addr.
REQ-027 SHALL, for a load/store accepted at edge T, perform the memory read/write at edge T+MEM_LATENCY-1 and pulse out_valid in the following cycle.
REQ-028 SHALL, when MEM_LATENCY>1, move to WAIT with a down-counter loaded to MEM_LATENCY-1 and return to IDLE when it reaches 0; back-to-back acceptance is allowed from IDLE.
REQ-029 SHALL give a load accepted after a store to the same word the stored data (no stale read).
REQ-030 SHALL give a store out_valid with result=0 and rd_out echoed.
REQ-031 SHALL give an errored request the same latency as a valid one of its type.
REQ-032 SHALL hold result/rd_out/flags stable until the next out_valid.

Reset
REQ-033 SHALL, while rst=0, force state=IDLE, counter=0, out_valid=0, result=0, rd_out=0, all flags=0, and in_ready=1 after release.
REQ-034 SHALL abort an in-flight access on reset mid-WAIT: no write, no out_valid.
REQ-035 SHALL NOT reset memory contents; they initialise to 0 at time zero.

Structure
REQ-036 SHALL place XLEN default, DATA_MEM_DEPTH, the funct3 encodings (lsu_size_e enum) and the lsu_req_t request struct in riscv_params_pkg.
REQ-037 SHALL put byte-lane select, byte-enable generation and sign/zero extension in one combinational sub-module, lsu_data_align.
REQ-038 SHALL keep the implementation within 120-400 lines of RTL.

Verification
REQ-039 SHALL test: SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> result=0xDEADBEEF, LB 0x13 -> 0xFFFFFFDE, LBU 0x13 -> 0x000000DE.
REQ-040 SHALL test: SH addr=0x22 data=0x1234ABCD over word 0x0 -> LW 0x20 = 0xABCD0000; LH 0x22 -> 0xFFFFABCD.
REQ-041 SHALL test: LW addr=0x6 -> exc_misalign=1, result=0; SW addr=0x6 leaves word 0x4 unchanged.
REQ-042 SHALL test: MEM_LATENCY=4, LW accepted at edge T -> in_ready low for 3 cycles, out_valid in the cycle after T+3, then a pass-through accepted immediately.
REQ-043 SHALL test: load with funct3=011 -> exc_illegal=1; word index = DATA_MEM_DEPTH -> exc_range=1.
REQ-044 SHALL test: rst driven low during WAIT of a SW -> no out_valid, target word unchanged, in_ready=1 after release.
